// File: rtl/ps2_rx_frame.sv
// PS/2 receive-only frame deserializer: synchronizes and glitch-filters the keyboard
// lines, assembles start/8 data/odd parity/stop frames and strobes out each good byte.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scancode_out,
  output logic       scancode_valid,
  output logic       frame_error,
  output logic [7:0] frame_count,
  output logic       rx_busy
);

  localparam int                FCNT_W    = $clog2(FILTER_LEN);
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [FCNT_W-1:0] FILT_ONE  = FCNT_W'(1);
  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TMO_ONE   = TCNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECEIVE = 1'b1
  } state_t;

  // Odd parity over data plus parity bit, qualified by a high stop bit.
  function automatic logic frame_good(input logic [7:0] data,
                                      input logic       par,
                                      input logic       stop);
    return ((^data) ^ par) & stop;
  endfunction

  logic              clk_meta_r;
  logic              clk_sync_r;
  logic              dat_meta_r;
  logic              dat_sync_r;
  logic [FCNT_W-1:0] filt_cnt_r;
  logic              clk_filt_r;
  logic              clk_filt_d_r;
  logic              fall_r;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        bit_idx_r;
  logic [3:0]        bit_idx_nxt_s;
  logic [7:0]        shreg_r;
  logic [7:0]        shreg_nxt_s;
  logic              parity_r;
  logic              parity_nxt_s;
  logic [TCNT_W-1:0] idle_cnt_r;
  logic [TCNT_W-1:0] idle_cnt_nxt_s;
  logic              valid_nxt_s;
  logic              err_nxt_s;

  // Two-flop synchronizers for both raw lines; idle-high reset avoids a false edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= PS2_CLK;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= PS2_DAT;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Clock filter: level follows clk_sync only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      filt_cnt_r <= {FCNT_W{1'b0}};
      clk_filt_r <= 1'b1;
    end else if (clk_sync_r == clk_filt_r) begin
      filt_cnt_r <= {FCNT_W{1'b0}};
    end else if (filt_cnt_r == FILT_LAST) begin
      filt_cnt_r <= {FCNT_W{1'b0}};
      clk_filt_r <= clk_sync_r;
    end else begin
      filt_cnt_r <= filt_cnt_r + FILT_ONE;
    end
  end

  // Registered falling-edge pulse of the filtered clock.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_filt_d_r <= 1'b1;
      fall_r       <= 1'b0;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      fall_r       <= clk_filt_d_r & ~clk_filt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, frame assembly and pulse decisions.
  always_comb begin
    state_nxt_s    = state_r;
    bit_idx_nxt_s  = bit_idx_r;
    shreg_nxt_s    = shreg_r;
    parity_nxt_s   = parity_r;
    idle_cnt_nxt_s = idle_cnt_r;
    valid_nxt_s    = 1'b0;
    err_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idle_cnt_nxt_s = {TCNT_W{1'b0}};
        if (fall_r) begin
          if (!dat_sync_r) begin
            state_nxt_s   = ST_RECEIVE;
            bit_idx_nxt_s = 4'd1;
            shreg_nxt_s   = 8'h00;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECEIVE: begin
        if (fall_r) begin
          idle_cnt_nxt_s = {TCNT_W{1'b0}};
          bit_idx_nxt_s  = bit_idx_r + 4'd1;
          case (bit_idx_r)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
              shreg_nxt_s[bit_idx_r[2:0] - 3'd1] = dat_sync_r;
            end
            4'd9: begin
              parity_nxt_s = dat_sync_r;
            end
            4'd10: begin
              state_nxt_s   = ST_IDLE;
              bit_idx_nxt_s = 4'd0;
              if (frame_good(shreg_r, parity_r, dat_sync_r)) begin
                valid_nxt_s = 1'b1;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
            default: begin
              state_nxt_s   = ST_IDLE;
              bit_idx_nxt_s = 4'd0;
              err_nxt_s     = 1'b1;
            end
          endcase
        end else if (idle_cnt_r == TMO_LAST) begin
          // Line went quiet mid-frame: drop the partial byte.
          state_nxt_s    = ST_IDLE;
          bit_idx_nxt_s  = 4'd0;
          shreg_nxt_s    = 8'h00;
          idle_cnt_nxt_s = {TCNT_W{1'b0}};
          err_nxt_s      = 1'b1;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + TMO_ONE;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        bit_idx_nxt_s  = 4'd0;
        idle_cnt_nxt_s = {TCNT_W{1'b0}};
      end
    endcase
  end

  // Frame datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bit_idx_r  <= 4'd0;
      shreg_r    <= 8'h00;
      parity_r   <= 1'b0;
      idle_cnt_r <= {TCNT_W{1'b0}};
    end else begin
      bit_idx_r  <= bit_idx_nxt_s;
      shreg_r    <= shreg_nxt_s;
      parity_r   <= parity_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end

  // Registered outputs; the byte and its strobe update together.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      scancode_out   <= 8'h00;
      scancode_valid <= 1'b0;
      frame_error    <= 1'b0;
      frame_count    <= 8'h00;
      rx_busy        <= 1'b0;
    end else begin
      scancode_valid <= valid_nxt_s;
      frame_error    <= err_nxt_s;
      rx_busy        <= (state_nxt_s == ST_RECEIVE);
      if (valid_nxt_s) begin
        scancode_out <= shreg_r;
        frame_count  <= frame_count + 8'd1;
      end else begin
        scancode_out <= scancode_out;
        frame_count  <= frame_count;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomized self-checking bench for ps2_rx_frame with a frame-level reference model.
module tb_ps2_rx_frame;
  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 10;
  // raw clock fall -> output pulse: 2 sync + FILT filter + 1 edge reg = fall cycle, +1 registered output
  localparam int LAT  = 2 + FILT + 1 + 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] scancode_out;
  logic       scancode_valid;
  logic       frame_error;
  logic [7:0] frame_count;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  ps2_rx_frame #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .PS2_CLK       (PS2_CLK),
    .PS2_DAT       (PS2_DAT),
    .scancode_out  (scancode_out),
    .scancode_valid(scancode_valid),
    .frame_error   (frame_error),
    .frame_count   (frame_count),
    .rx_busy       (rx_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // observed events
  logic [7:0] got_q[$];
  int   n_valid = 0, n_err = 0, n_both = 0, n_wide = 0;
  int   last_valid_cyc = 0, last_err_cyc = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  always @(negedge CLOCK_50) begin
    if (scancode_valid) begin
      got_q.push_back(scancode_out);
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_error) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (scancode_valid && frame_error) n_both <= n_both + 1;
    if ((scancode_valid && prev_v) || (frame_error && prev_e)) n_wide <= n_wide + 1;
    prev_v <= scancode_valid;
    prev_e <= frame_error;
  end

  // reference model
  logic [7:0] exp_q[$];
  logic [7:0] exp_out   = 8'h00;
  int         exp_count = 0;
  int         last_fall_cyc = 0;
  int         stop_fall_cyc = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // One PS/2 bit: data set mid-high, then clock low and high for half cycles each.
  task automatic ps2_bit(input logic b, input int half, input logic glitch);
    if (glitch) begin
      wait_cyc(12);
      PS2_CLK = 1'b0;
      wait_cyc(5);
      PS2_CLK = 1'b1;
      wait_cyc(12);
    end
    wait_cyc(half / 2);
    PS2_DAT = b;
    wait_cyc(half - half / 2);
    PS2_CLK = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(half);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                            input int half, input logic [10:0] gmask, input int gap);
    logic [10:0] bits;
    bits = {stop_bit, (~(^d)) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], half, gmask[i]);
    stop_fall_cyc = last_fall_cyc;
    PS2_DAT = 1'b1;
    wait_cyc(gap);
    if (!par_flip && stop_bit) begin
      exp_q.push_back(d);
      exp_out   = d;
      exp_count = (exp_count + 1) % 256;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    wait_cyc(5);
    total++; if (scancode_out !== 8'h00) begin bad++; $display("FAIL rst_out: got %0h want 00", scancode_out); end
    total++; if (scancode_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", scancode_valid); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", frame_error); end
    total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL rst_count: got %0d want 0", frame_count); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", rx_busy); end
    reset = 1'b0;
    wait_cyc(30);
    total++; if (n_valid + n_err !== 0) begin bad++; $display("FAIL rst_quiet: got %0d pulses want 0", n_valid + n_err); end
  endtask

  task automatic test_good_frame();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1D, 1'b0, 1'b1, HALF, 11'h000, 20);
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL good_nvalid: got %0d want 1", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL good_nerr: got %0d want 0", n_err - e0); end
    total++; if (scancode_out !== 8'h1D) begin bad++; $display("FAIL good_out: got %0h want 1d", scancode_out); end
    total++; if (frame_count !== 8'(exp_count)) begin bad++; $display("FAIL good_count: got %0d want %0d", frame_count, exp_count); end
    total++; if (last_valid_cyc !== stop_fall_cyc + LAT) begin bad++; $display("FAIL good_latency: got %0d want %0d", last_valid_cyc - stop_fall_cyc, LAT); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL good_busy: got %0b want 0", rx_busy); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL good_byte: got %0h want %0h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = n_err;
    send_frame(8'hF0, 1'b0, 1'b1, HALF, 11'h000, 6);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_gap: got %0b want 0", rx_busy); end
    total++; if (scancode_out !== 8'hF0) begin bad++; $display("FAIL b2b_first: got %0h want f0", scancode_out); end
    send_frame(8'h1D, 1'b0, 1'b1, HALF, 11'h000, 20);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_nvalid: got %0d want 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_order: got %0h want %0h", g, e); end
    end
    total++; if (frame_count !== 8'(exp_count)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count); end
    total++; if (n_err !== e0) begin bad++; $display("FAIL b2b_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_frame_errors();
    int v0, e0;
    logic [7:0] d;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, HALF, 11'h000, 20);
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL par_nerr: got %0d want 1", n_err - e0); end
    total++; if (last_err_cyc !== stop_fall_cyc + LAT) begin bad++; $display("FAIL par_latency: got %0d want %0d", last_err_cyc - stop_fall_cyc, LAT); end
    total++; if (scancode_out !== exp_out) begin bad++; $display("FAIL par_hold: got %0h want %0h", scancode_out, exp_out); end
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b0, HALF, 11'h000, 20);
    total++; if (n_err - e0 !== 2) begin bad++; $display("FAIL stop_nerr: got %0d want 2", n_err - e0); end
    ps2_bit(1'b1, HALF, 1'b0);
    wait_cyc(20);
    total++; if (n_err - e0 !== 3) begin bad++; $display("FAIL start_nerr: got %0d want 3", n_err - e0); end
    total++; if (last_err_cyc !== last_fall_cyc + LAT) begin bad++; $display("FAIL start_latency: got %0d want %0d", last_err_cyc - last_fall_cyc, LAT); end
    total++; if (n_valid !== v0) begin bad++; $display("FAIL err_novalid: got %0d want 0", n_valid - v0); end
    total++; if (frame_count !== 8'(exp_count)) begin bad++; $display("FAIL err_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_timeout();
    int v0, e0, tf;
    v0 = n_valid; e0 = n_err;
    ps2_bit(1'b0, HALF, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom), HALF, 1'b0);
    tf = last_fall_cyc;
    PS2_DAT = 1'b1;
    wait_cyc(20);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL tmo_busy_mid: got %0b want 1", rx_busy); end
    wait_cyc(1100);
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL tmo_nerr: got %0d want 1", n_err - e0); end
    total++; if (last_err_cyc !== tf + LAT + TMO) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", last_err_cyc - tf, LAT + TMO); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %0b want 0", rx_busy); end
    total++; if (n_valid !== v0) begin bad++; $display("FAIL tmo_novalid: got %0d want 0", n_valid - v0); end
    send_frame(8'h23, 1'b0, 1'b1, HALF, 11'h000, 20);
    total++; if (scancode_out !== 8'h23) begin bad++; $display("FAIL tmo_next: got %0h want 23", scancode_out); end
    total++; if (frame_count !== 8'(exp_count)) begin bad++; $display("FAIL tmo_count: got %0d want %0d", frame_count, exp_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1B, 1'b0, 1'b1, HALF, 11'b000_0111_1001, 20);
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL glitch_nvalid: got %0d want 1", n_valid - v0); end
    total++; if (n_err !== e0) begin bad++; $display("FAIL glitch_err: got %0d want 0", n_err - e0); end
    total++; if (scancode_out !== 8'h1B) begin bad++; $display("FAIL glitch_out: got %0h want 1b", scancode_out); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int v0, e0, exp_errs, mism;
    v0 = n_valid; e0 = n_err; exp_errs = 0; mism = 0;
    for (int f = 0; f < 24; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) exp_errs++;
      send_frame(8'($urandom), kind == 0, kind != 1, $urandom_range(10, 14),
                 11'($urandom & $urandom & $urandom), $urandom_range(6, 30));
    end
    total++; if (n_err - e0 !== exp_errs) begin bad++; $display("FAIL rnd_nerr: got %0d want %0d", n_err - e0, exp_errs); end
    total++; if (n_valid - v0 !== exp_q.size()) begin bad++; $display("FAIL rnd_nvalid: got %0d want %0d", n_valid - v0, exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) if (got_q.pop_front() !== exp_q.pop_front()) mism++;
    mism += got_q.size() + exp_q.size();
    total++; if (mism !== 0) begin bad++; $display("FAIL rnd_bytes: got %0d mismatching want 0", mism); end
    total++; if (frame_count !== 8'(exp_count)) begin bad++; $display("FAIL rnd_count: got %0d want %0d", frame_count, exp_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_wrap();
    int v0, e0, mism;
    ps2_bit(1'b0, HALF, 1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(1'($urandom), HALF, 1'b0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    total++; if ({scancode_out, scancode_valid, frame_error, frame_count, rx_busy} !== 19'h0)
      begin bad++; $display("FAIL wrap_rst_vals: got out=%0h v=%0b e=%0b cnt=%0d busy=%0b want all 0", scancode_out, scancode_valid, frame_error, frame_count, rx_busy); end
    reset = 1'b0; PS2_DAT = 1'b1;
    exp_out = 8'h00; exp_count = 0;
    got_q.delete(); exp_q.delete();
    v0 = n_valid; e0 = n_err;
    wait_cyc(40);
    total++; if (n_valid + n_err !== v0 + e0) begin bad++; $display("FAIL wrap_no_pulse: got %0d pulses want 0", n_valid + n_err - v0 - e0); end
    total++; if (scancode_out !== 8'h00) begin bad++; $display("FAIL wrap_out_held: got %0h want 00", scancode_out); end
    for (int f = 0; f < 256; f++) send_frame(8'($urandom), 1'b0, 1'b1, HALF, 11'h000, 8);
    total++; if (n_valid - v0 !== 256) begin bad++; $display("FAIL wrap_nvalid: got %0d want 256", n_valid - v0); end
    total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL wrap_count: got %0d want 0", frame_count); end
    total++; if (scancode_out !== exp_out) begin bad++; $display("FAIL wrap_out: got %0h want %0h", scancode_out, exp_out); end
    mism = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) if (got_q.pop_front() !== exp_q.pop_front()) mism++;
    mism += got_q.size() + exp_q.size();
    total++; if (mism !== 0) begin bad++; $display("FAIL wrap_bytes: got %0d mismatching want 0", mism); end
    total++; if (n_err !== e0) begin bad++; $display("FAIL wrap_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_pulse_shape();
    total++; if (n_both !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", n_both); end
    total++; if (n_wide !== 0) begin bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_wrap();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
